fetch_unit: RTL

- Instruction-fetch stage placed directly downstream of the PC register.
- Consumes the registered `pc`, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses with their PCs in a small FIFO.
- Presents `{instr, pc}` to decode under a valid/ready handshake.
- Computes `pc_next` back to the PC register: sequential +4, hold, or redirect on branch/jump.

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage downstream of the PC register.
// Issues word reads under a credit limit, tracks the PCs of outstanding
// requests, buffers in-order responses and hands {instr, pc} to decode.
// A redirect flushes everything and arms a counter that discards the
// responses still owed for requests issued before it.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        misalign
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // instruction buffer
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic [AW-1:0] buf_head;
    logic [AW-1:0] buf_tail;
    logic [CW-1:0] count;

    // PCs of requests awaiting a response
    logic [31:0]   afifo [DEPTH];
    logic [AW-1:0] af_head;
    logic [AW-1:0] af_tail;

    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic          misalign_q;

    logic [CW:0]   used;
    logic          credit_ok;
    logic          fire;
    logic          resp_live;
    logic          resp_drop;
    logic          buf_push;
    logic          buf_pop;

    // credit check, handshakes and response classification
    always_comb begin
        used           = {1'b0, inflight} + {1'b0, count};
        credit_ok      = used < DEPTH_W;
        imem_req_valid = rst & ~redirect_valid & credit_ok;
        fire           = imem_req_valid & imem_req_ready;
        resp_live      = imem_resp_valid & (inflight != '0);
        resp_drop      = resp_live & (drop_cnt != '0);
        buf_push       = resp_live & (drop_cnt == '0) & ~redirect_valid & rst;
        buf_pop        = (count != '0) & id_ready & ~redirect_valid;
    end

    // next PC: reset, redirect (word aligned), sequential, or hold
    always_comb begin
        pc_next = pc;
        if (!rst)
            pc_next = RESET_PC;
        else if (redirect_valid)
            pc_next = {redirect_pc[31:2], 2'b00};
        else if (fire)
            pc_next = pc + 32'd4;
    end

    // pointers, occupancy, in-flight and drop counters, misalign flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_head   <= '0;
            buf_tail   <= '0;
            count      <= '0;
            af_head    <= '0;
            af_tail    <= '0;
            inflight   <= '0;
            drop_cnt   <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid & (|redirect_pc[1:0]);
            if (redirect_valid) begin
                buf_head <= '0;
                buf_tail <= '0;
                count    <= '0;
                af_head  <= '0;
                af_tail  <= '0;
                // every outstanding request becomes a drop, minus the
                // response arriving now (discarded along with the flush)
                inflight <= inflight - CW'(resp_live);
                drop_cnt <= inflight - CW'(resp_live);
            end else begin
                if (fire)
                    af_tail <= af_tail + AW'(1);
                if (buf_push)
                    af_head <= af_head + AW'(1);
                if (buf_push)
                    buf_tail <= buf_tail + AW'(1);
                if (buf_pop)
                    buf_head <= buf_head + AW'(1);
                count    <= count + CW'(buf_push) - CW'(buf_pop);
                inflight <= inflight + CW'(fire) - CW'(resp_live);
                if (resp_drop)
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // storage writes: request PCs and buffered {pc, instr} pairs
    always_ff @(posedge clk) begin
        if (fire)
            afifo[af_tail] <= pc;
        if (buf_push) begin
            buf_pc[buf_tail]    <= afifo[af_head];
            buf_instr[buf_tail] <= imem_resp_data;
        end
    end

    assign imem_req_addr = pc;
    assign if_valid      = (count != '0);
    assign if_instr      = buf_instr[buf_head];
    assign if_pc         = buf_pc[buf_head];
    assign misalign      = misalign_q;

    // the credit rule keeps the buffer from ever overflowing
    assert property (@(posedge clk) disable iff (!rst)
        !(buf_push && !buf_pop && (count == CW'(DEPTH))));

endmodule
